rr_stream_mux: RTL and testbench

Parametrised N-channel, W-bit streaming multiplexer that generalises the team's 2:1 select mux into a registered, flow-controlled block. Channels present beats with valid/ready/last; a round-robin arbiter picks one channel, locks to it for a whole packet, and forwards beats through a one-entry output register tagged with the source channel ID. It sits between several producer stages and a single shared consumer such as a bus port or a serialiser.

---
 rtl/rr_stream_mux_pkg.sv | 16 +
 rtl/rr_stream_mux_arbiter.sv | 32 +++
 rtl/rr_stream_mux.sv | 112 +++++++++++
 tb/tb_rr_stream_mux.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rr_stream_mux_pkg.sv
// Shared types and helpers for the round-robin packet stream multiplexer.
package rr_stream_mux_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Channel-ID width; never narrower than one bit.
  function automatic int unsigned ch_width(input int unsigned n);
    int unsigned w;
    w = (n > 1) ? $clog2(n) : 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Rotating-priority arbiter: first request at or above base, wrapping modulo N_CH.
module rr_arbiter
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  localparam int unsigned CH_W = ch_width(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] base,
  output logic [N_CH-1:0] grant_c,
  output logic [CH_W-1:0] grant_idx_c
);

  logic            found;
  logic [CH_W-1:0] idx;

  always_comb begin
    grant_c     = '0;
    grant_idx_c = '0;
    found       = 1'b0;
    idx         = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = CH_W'((32'(base) + k) % N_CH);
      if (!found && req[idx]) begin
        found        = 1'b1;
        grant_c[idx] = 1'b1;
        grant_idx_c  = idx;
      end
    end
  end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel packet-locked round-robin stream mux with a one-entry output register.
module rr_stream_mux
  import rr_stream_mux_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CH_W = ch_width(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic [CH_W-1:0]       out_ch,
  input  logic                  out_ready
);

  state_t          state_q, state_d;
  logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0] lock_ch_q, lock_ch_d;

  logic [N_CH-1:0]  req_c;
  logic [CH_W-1:0]  base_c;
  logic [N_CH-1:0]  grant_c;
  logic [CH_W-1:0]  grant_idx_c;
  logic             load_en_c;
  logic             accept_c;
  logic             acc_last_c;
  logic [WIDTH-1:0] acc_data_c;

  // While locked, only the locked channel may request.
  always_comb begin
    req_c  = in_valid;
    base_c = rr_ptr_q;
    if (state_q == LOCKED) begin
      req_c  = in_valid & (N_CH'(1) << lock_ch_q);
      base_c = lock_ch_q;
    end
  end

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req         (req_c),
    .base        (base_c),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  assign load_en_c = !out_valid || out_ready;
  assign in_ready  = (rst_n && load_en_c) ? grant_c : '0;
  assign accept_c  = |(in_ready & in_valid);

  always_comb begin
    acc_data_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant_c[i]) acc_data_c = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign acc_last_c = |(grant_c & in_last);

  // Next-state: lock on a non-last beat, release and advance pointer on a last beat.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    if (accept_c) begin
      if (acc_last_c) begin
        state_d  = IDLE;
        rr_ptr_d = (grant_idx_c == CH_W'(N_CH - 1)) ? '0 : grant_idx_c + CH_W'(1);
      end else begin
        state_d   = LOCKED;
        lock_ch_d = grant_idx_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      lock_ch_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  // Output register: load on acceptance, drain when consumer takes the beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_data  <= acc_data_c;
      out_last  <= acc_last_c;
      out_ch    <= grant_idx_c;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed vector bench for rr_stream_mux (4 channels, 8-bit data).
module tb_rr_stream_mux;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned WIDTH = 8;

  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_ch;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  rr_stream_mux #(
    .N_CH  (N_CH),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_last;
    logic [1:0]  exp_ch;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input logic o, input logic [3:0] er,
                              input logic ev, input logic [7:0] ed, input logic el,
                              input logic [1:0] ec);
    vec_t t;
    t.rst_n = r; t.valid = v; t.last = l; t.data = d; t.ordy = o;
    t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed; t.exp_last = el; t.exp_ch = ec;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] hs_d[4];
  logic [1:0] hs_c[4];
  logic       hs_l[4];

  initial begin
    rst_n = 1'b0; in_data = '0; in_valid = '0; in_last = '0; out_ready = 1'b1;

    // Reset, with all channels requesting
    vecs.push_back(mk(0, 4'hF, 4'hF, 32'h0, 1, 4'h0, 0, 8'h00, 0, 2'd0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 32'h0, 1, 4'h0, 0, 8'h00, 0, 2'd0));
    // ch2 three-beat packet
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 32'h00110000, 1, 4'b0100, 1, 8'h11, 0, 2'd2));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 32'h00220000, 1, 4'b0100, 1, 8'h22, 0, 2'd2));
    vecs.push_back(mk(1, 4'b0100, 4'b0100, 32'h00330000, 1, 4'b0100, 1, 8'h33, 1, 2'd2));
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 0, 8'h33, 1, 2'd2));
    // Pointer at 3 wraps: ch0 beats ch2
    vecs.push_back(mk(1, 4'b0101, 4'b0101, 32'h00C200C0, 1, 4'b0001, 1, 8'hC0, 1, 2'd0));
    // Reset, then all four channels with single-beat packets
    vecs.push_back(mk(0, 4'b1111, 4'b1111, 32'h0,        1, 4'b0000, 0, 8'h00, 0, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0001, 1, 8'hA0, 1, 2'd0));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0010, 1, 8'hA1, 1, 2'd1));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0100, 1, 8'hA2, 1, 2'd2));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b1000, 1, 8'hA3, 1, 2'd3));
    vecs.push_back(mk(1, 4'b1111, 4'b1111, 32'hA3A2A1A0, 1, 4'b0001, 1, 8'hA0, 1, 2'd0));
    // ch1 locks, stalls for two cycles while ch0/ch3 wait, then finishes
    vecs.push_back(mk(1, 4'b1011, 4'b1001, 32'h63005160, 1, 4'b0010, 1, 8'h51, 0, 2'd1));
    vecs.push_back(mk(1, 4'b1001, 4'b1001, 32'h63000060, 1, 4'b0000, 0, 8'h51, 0, 2'd1));
    vecs.push_back(mk(1, 4'b1001, 4'b1001, 32'h63000060, 1, 4'b0000, 0, 8'h51, 0, 2'd1));
    vecs.push_back(mk(1, 4'b1011, 4'b1011, 32'h63005260, 1, 4'b0010, 1, 8'h52, 1, 2'd1));
    vecs.push_back(mk(1, 4'b1001, 4'b1001, 32'h63000060, 1, 4'b1000, 1, 8'h63, 1, 2'd3));
    // Backpressure holds 0xA5, then drain and load in one cycle
    vecs.push_back(mk(1, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 0, 8'h63, 1, 2'd3));
    vecs.push_back(mk(1, 4'b0001, 4'b0000, 32'h000000A5, 0, 4'b0001, 1, 8'hA5, 0, 2'd0));
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 32'h000000B6, 0, 4'b0000, 1, 8'hA5, 0, 2'd0));
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 32'h000000B6, 0, 4'b0000, 1, 8'hA5, 0, 2'd0));
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 32'h000000B6, 0, 4'b0000, 1, 8'hA5, 0, 2'd0));
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 32'h000000B6, 1, 4'b0001, 1, 8'hB6, 1, 2'd0));
    // Reset in the middle of a locked ch3 packet; ch0 wins afterwards
    vecs.push_back(mk(1, 4'b1000, 4'b0000, 32'h71000000, 1, 4'b1000, 1, 8'h71, 0, 2'd3));
    vecs.push_back(mk(0, 4'b1001, 4'b0000, 32'h72000080, 1, 4'b0000, 0, 8'h00, 0, 2'd0));
    vecs.push_back(mk(1, 4'b1001, 4'b1001, 32'h83000080, 1, 4'b0001, 1, 8'h80, 1, 2'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n     = vecs[i].rst_n;
      in_valid  = vecs[i].valid;
      in_last   = vecs[i].last;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d out_data", i),  32'(out_data),  32'(vecs[i].exp_data));
      check($sformatf("v%0d out_last", i),  32'(out_last),  32'(vecs[i].exp_last));
      check($sformatf("v%0d out_ch", i),    32'(out_ch),    32'(vecs[i].exp_ch));
    end

    // ch1 three-beat packet under alternating out_ready; 0x80 still held from above
    hs_d = '{8'h80, 8'h91, 8'h92, 8'h93};
    hs_c = '{2'd0, 2'd1, 2'd1, 2'd1};
    hs_l = '{1'b1, 1'b0, 1'b0, 1'b1};
    begin
      int  sent;
      int  got;
      logic fire_in;
      sent = 0;
      got  = 0;
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
        out_ready = ((cyc % 2) == 1);
        in_valid  = (sent < 3) ? 4'b0010 : 4'b0000;
        in_last   = (sent == 2) ? 4'b0010 : 4'b0000;
        in_data   = {8'h00, 8'h00, 8'(8'h91 + sent), 8'h00};
        #1;
        fire_in = in_valid[1] & in_ready[1];
        if (out_valid && out_ready) begin
          check($sformatf("hs beat%0d data", got), 32'(out_data), 32'(hs_d[got]));
          check($sformatf("hs beat%0d ch", got),   32'(out_ch),   32'(hs_c[got]));
          check($sformatf("hs beat%0d last", got), 32'(out_last), 32'(hs_l[got]));
          got++;
        end
        @(posedge clk); #1;
        if (fire_in) sent++;
      end
      check("hs beats received", 32'(got), 32'd4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
